genram_loader: RTL and testbench

- Byte-addressed RAM that answers the core's instruction/data fetch port (mem_addr / mem_extra -> mem_data / mem_error).
- Same read-port contract as genrom, so it drops into any core bench in genrom's place.
- Contents arrive through a byte-serial valid/ready write stream controlled by a small load FSM, so a host or UART bridge can download a wasm image before releasing the core from reset.

---
 rtl/genram_loader.sv | 141 ++++++++++++++
 tb/tb_genram_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/genram_loader.sv
// Byte-addressed RAM with a wide registered read port and a byte-serial load stream.
// The load FSM owns write access; reads are always served but flagged unless a load has finished.
module genram_loader #(
  parameter int AW    = 6,
  parameter int DW    = 8,
  parameter int EXTRA = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AW:0]               addr,
  input  logic [EXTRA-1:0]          extra,
  input  logic [AW:0]               lower_bound,
  input  logic [AW:0]               upper_bound,
  output logic [(2**EXTRA)*8-1:0]   data,
  output logic                      error,
  input  logic                      load_start,
  input  logic [AW:0]               load_base,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DW-1:0]             wr_data,
  input  logic                      wr_last,
  output logic                      loaded,
  output logic                      load_error
);

  localparam int NB    = 2**EXTRA;
  localparam int DEPTH = 2**AW;
  localparam int EW    = AW + 2;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [AW:0]         ptr_q, ptr_d;
  logic                ready_q, ready_d;
  logic                loaded_q, loaded_d;
  logic                lerr_q, lerr_d;
  logic [NB*8-1:0]     data_q, data_d;
  logic                error_q, error_d;

  logic [DW-1:0]       mem [DEPTH];

  logic                hs;
  logic                wr_en;
  logic [EW-1:0]       rd_end;

  // A load_start in the same cycle as a handshake wins: that byte is dropped.
  assign hs    = wr_valid && ready_q && !load_start;
  assign wr_en = hs && !ptr_q[AW];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    loaded_d = loaded_q;
    lerr_d   = lerr_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d  = LOAD;
          ptr_d    = load_base;
          loaded_d = 1'b0;
          lerr_d   = 1'b0;
        end
      end
      LOAD: begin
        if (load_start) begin
          ptr_d    = load_base;
          loaded_d = 1'b0;
          lerr_d   = 1'b0;
        end else if (hs) begin
          if (ptr_q[AW]) begin
            lerr_d = 1'b1;
          end
          // Saturate rather than wrap so an overlong stream cannot clobber low memory.
          if (ptr_q != '1) begin
            ptr_d = ptr_q + 1'b1;
          end
          if (wr_last) begin
            state_d  = DONE;
            loaded_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ready_q  <= 1'b0;
      loaded_q <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ready_q  <= ready_d;
      loaded_q <= loaded_d;
      lerr_q   <= lerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // End address is one bit wider than the port so addr+extra never aliases low memory.
  assign rd_end  = EW'(addr) + EW'(extra);
  assign error_d = (addr < lower_bound) ||
                   (rd_end > EW'(upper_bound)) ||
                   (rd_end[EW-1:AW] != '0) ||
                   (state_q != DONE);

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [AW-1:0] idx;
      assign idx = addr[AW-1:0] + AW'(gi);
      assign data_d[8*gi +: 8] = (!error_d && (32'(gi) <= 32'(extra))) ? mem[idx] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  assign data       = data_q;
  assign error      = error_q;
  assign wr_ready   = ready_q;
  assign loaded     = loaded_q;
  assign load_error = lerr_q;

endmodule

// File: tb/tb_genram_loader.sv
// Bench for genram_loader: directed load/read scenarios plus randomized loads and reads,
// every cycle compared against a byte-array reference of the RAM and load status.
module tb_genram_loader;

  localparam int AW    = 6;
  localparam int EXTRA = 4;
  localparam int NB    = 16;
  localparam int DEPTH = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW:0]       addr;
  logic [EXTRA-1:0]  extra;
  logic [AW:0]       lower_bound;
  logic [AW:0]       upper_bound;
  logic [NB*8-1:0]   data;
  logic              error;
  logic              load_start;
  logic [AW:0]       load_base;
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        wr_data;
  logic              wr_last;
  logic              loaded;
  logic              load_error;

  always #5 clk = ~clk;

  genram_loader #(.AW(AW), .DW(8), .EXTRA(EXTRA)) dut (
    .clk(clk), .reset(reset),
    .addr(addr), .extra(extra), .lower_bound(lower_bound), .upper_bound(upper_bound),
    .data(data), .error(error),
    .load_start(load_start), .load_base(load_base),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .loaded(loaded), .load_error(load_error)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: RAM image plus load status (phase 0 idle, 1 loading, 2 done).
  logic [7:0]   m_mem [DEPTH];
  int           m_phase  = 0;
  int           m_ptr    = 0;
  bit           m_ready  = 0;
  bit           m_loaded = 0;
  bit           m_lerr   = 0;
  logic [127:0] m_data   = '0;
  bit           m_err    = 0;

  initial begin
    int a, e, lb, ub;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m_phase = 0; m_ptr = 0; m_ready = 0; m_loaded = 0; m_lerr = 0;
        m_data = '0; m_err = 0;
      end else begin
        a = int'(addr); e = int'(extra); lb = int'(lower_bound); ub = int'(upper_bound);
        m_err  = (a < lb) || (a + e > ub) || (a + e >= DEPTH) || (m_phase != 2);
        m_data = '0;
        if (!m_err) begin
          for (int k = 0; k <= e; k++) m_data[8*k +: 8] = m_mem[a + k];
        end
        if (load_start) begin
          m_phase = 1; m_ptr = int'(load_base); m_loaded = 0; m_lerr = 0;
        end else if (m_phase == 1 && m_ready && wr_valid) begin
          if (m_ptr < DEPTH) m_mem[m_ptr] = wr_data;
          else m_lerr = 1;
          if (m_ptr < 2*DEPTH - 1) m_ptr++;
          if (wr_last) begin
            m_phase = 2; m_loaded = 1;
          end
        end
        m_ready = (m_phase == 1);
      end
      chk("data", data, m_data);
      chk("error", {127'd0, error}, {127'd0, m_err});
      chk("wr_ready", {127'd0, wr_ready}, {127'd0, m_ready});
      chk("loaded", {127'd0, loaded}, {127'd0, m_loaded});
      chk("load_error", {127'd0, load_error}, {127'd0, m_lerr});
    end
  end

  logic [7:0] stream_bytes [64];
  bit         rand_reads = 0;

  task automatic rand_read_inputs();
    addr        = 7'($urandom_range(0, 70));
    extra       = 4'($urandom_range(0, 15));
    lower_bound = 7'($urandom_range(0, 20));
    upper_bound = 7'($urandom_range(30, 127));
  endtask

  // Streams stream_bytes[0..n-1] from base; mode 0 valid held, 1 toggled, 2 random.
  task automatic load_bytes(input int base, input int n, input int mode, input int stop_after,
                            input int restart_at, output int hs_n, output int cyc);
    int budget;
    bit restarted;
    bit hs;
    bit rst_now;
    budget = 2000; restarted = 0; hs_n = 0; cyc = 0;
    load_start = 1'b1; load_base = 7'(base); wr_valid = 1'b0; wr_last = 1'b0;
    if (rand_reads) rand_read_inputs();
    @(negedge clk);
    load_start = 1'b0;
    while (hs_n < n && budget > 0 && hs_n != stop_after) begin
      wr_data = stream_bytes[hs_n];
      wr_last = (hs_n == n - 1);
      case (mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = (cyc % 2 == 0);
        default: wr_valid = 1'($urandom_range(0, 1));
      endcase
      rst_now = 0;
      if (!restarted && hs_n == restart_at) begin
        load_start = 1'b1; restarted = 1; rst_now = 1; hs = 0;
      end else begin
        hs = wr_valid && wr_ready;
      end
      if (rand_reads) rand_read_inputs();
      @(negedge clk);
      load_start = 1'b0; cyc++; budget--;
      if (rst_now) hs_n = 0;
      else if (hs) hs_n++;
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("load_budget", {127'd0, budget > 0}, {127'd0, 1'b1});
  endtask

  initial begin
    int hs_n, cyc, n, base, rs;
    logic [127:0] exp;
    reset = 1'b0; addr = '0; extra = '0; lower_bound = '0; upper_bound = 7'd127;
    load_start = 1'b0; load_base = '0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", {127'd0, wr_ready}, 128'd0);
    chk("rst_loaded", {127'd0, loaded}, 128'd0);
    reset = 1'b0;

    // 1: not loaded -> fault
    @(negedge clk);
    chk("t1_error", {127'd0, error}, 128'd1);
    chk("t1_data", data, 128'd0);

    // 2: full image, valid held high
    for (int i = 0; i < 64; i++) stream_bytes[i] = 8'(i);
    load_bytes(0, 64, 0, -1, -1, hs_n, cyc);
    chk("t2_handshakes", 128'(hs_n), 128'd64);
    chk("t2_cycles", 128'(cyc), 128'd64);
    chk("t2_loaded", {127'd0, loaded}, 128'd1);
    chk("t2_ready", {127'd0, wr_ready}, 128'd0);
    addr = 7'd33; extra = 4'd3;
    @(negedge clk);
    chk("t2_read", data, 128'h24232221);
    chk("t2_error", {127'd0, error}, 128'd0);

    // 3: bound checks
    upper_bound = 7'd40; addr = 7'd38; extra = 4'd3;
    @(negedge clk);
    chk("t3_err_hi", {127'd0, error}, 128'd1);
    chk("t3_data_zero", data, 128'd0);
    addr = 7'd40; extra = 4'd0;
    @(negedge clk);
    chk("t3_edge", data, 128'h28);
    chk("t3_edge_err", {127'd0, error}, 128'd0);

    // 4: download running off the top of storage
    upper_bound = 7'd127;
    for (int i = 0; i < 4; i++) stream_bytes[i] = 8'hA0 + 8'(i);
    load_bytes(62, 4, 0, -1, -1, hs_n, cyc);
    chk("t4_loaded", {127'd0, loaded}, 128'd1);
    chk("t4_lerr", {127'd0, load_error}, 128'd1);
    addr = 7'd62; extra = 4'd1;
    @(negedge clk);
    chk("t4_read", data, 128'hA1A0);
    addr = 7'd0; extra = 4'd1;
    @(negedge clk);
    chk("t4_low_intact", data, 128'h0100);

    // 5: valid toggling
    for (int i = 0; i < 20; i++) stream_bytes[i] = 8'($urandom);
    load_bytes(5, 20, 1, -1, -1, hs_n, cyc);
    chk("t5_handshakes", 128'(hs_n), 128'd20);
    chk("t5_cycles", 128'(cyc), 128'd39);
    chk("t5_lerr", {127'd0, load_error}, 128'd0);
    exp = '0;
    for (int k = 0; k < 16; k++) exp[8*k +: 8] = stream_bytes[k];
    addr = 7'd5; extra = 4'd15;
    @(negedge clk);
    chk("t5_read", data, exp);

    // 6: reset in the middle of a download
    rand_reads = 1;
    for (int i = 0; i < 64; i++) stream_bytes[i] = 8'($urandom);
    load_bytes(0, 30, 0, 10, -1, hs_n, cyc);
    chk("t6_stop_count", 128'(hs_n), 128'd10);
    reset = 1'b1;
    #1;
    chk("t6_async_ready", {127'd0, wr_ready}, 128'd0);
    chk("t6_async_loaded", {127'd0, loaded}, 128'd0);
    chk("t6_async_lerr", {127'd0, load_error}, 128'd0);
    chk("t6_async_error", {127'd0, error}, 128'd0);
    chk("t6_async_data", data, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    load_bytes(0, 64, 2, -1, -1, hs_n, cyc);
    chk("t6_reload_count", 128'(hs_n), 128'd64);
    chk("t6_reload_loaded", {127'd0, loaded}, 128'd1);

    // Randomized loads, restarts and reads
    for (int t = 0; t < 40; t++) begin
      n    = $urandom_range(1, 20);
      base = ($urandom_range(0, 3) == 0) ? $urandom_range(56, 127) : $urandom_range(0, 63);
      rs   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < n; i++) stream_bytes[i] = 8'($urandom);
      load_bytes(base, n, 2, -1, rs, hs_n, cyc);
      repeat (5) begin
        rand_read_inputs();
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
